// File: rtl/debounced_edge_pulser.sv
// Per-channel push-button conditioner: 2-flop synchroniser, 4-state debounce FSM,
// edge pulse generation and optional auto-repeat while a channel is held high.
module debounced_edge_pulser #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned EDGE_MODE       = 0,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned HOLD_CYCLES     = 1000,
  parameter int unsigned REPEAT_CYCLES   = 250,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] level_i,
  output logic [WIDTH-1:0] pulse_o,
  output logic [WIDTH-1:0] held_o
);

  localparam longint unsigned CntMax = (64'd1 << CNT_WIDTH) - 64'd1;

  if (WIDTH < 1 || WIDTH > 32 || EDGE_MODE > 2 ||
      DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > CntMax ||
      HOLD_CYCLES < 1 || HOLD_CYCLES > CntMax ||
      REPEAT_CYCLES < 1 || REPEAT_CYCLES > CntMax) begin : g_cfg_err
    $error("debounced_edge_pulser: parameter out of range");
  end

  localparam logic [CNT_WIDTH-1:0] DebCnt  = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] HoldCnt = CNT_WIDTH'(HOLD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] RepCnt  = CNT_WIDTH'(REPEAT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);
  localparam bit RiseEn   = (EDGE_MODE != 1);
  localparam bit FallEn   = (EDGE_MODE != 0);
  localparam bit RepeatOn = (REPEAT_EN != 0) && (EDGE_MODE != 1);

  typedef enum logic [1:0] {StLow, StLowPend, StHigh, StHighPend} state_e;

  state_e               state_q [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_q   [WIDTH];
  logic [CNT_WIDTH-1:0] rep_q   [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_inc [WIDTH];
  logic [CNT_WIDTH-1:0] rep_inc [WIDTH];
  logic [WIDTH-1:0]     rep_phase_q;  // 0: waiting for first repeat, 1: periodic repeats
  logic [WIDTH-1:0]     s1_q, s2_q, pulse_q, held_q;

  // Saturating increments so counters can never wrap.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_inc[i] = (&cnt_q[i]) ? cnt_q[i] : cnt_q[i] + CntOne;
      rep_inc[i] = (&rep_q[i]) ? rep_q[i] : rep_q[i] + CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q        <= '0;
      s2_q        <= '0;
      pulse_q     <= '0;
      held_q      <= '0;
      rep_phase_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= StLow;
        cnt_q[i]   <= '0;
        rep_q[i]   <= '0;
      end
    end else begin
      s1_q <= level_i;
      s2_q <= s1_q;
      for (int i = 0; i < WIDTH; i++) begin
        pulse_q[i] <= 1'b0;
        unique case (state_q[i])
          StLow: begin
            if (s2_q[i]) begin
              state_q[i] <= StLowPend;
              cnt_q[i]   <= CntOne;
            end
          end
          StLowPend: begin
            if (!s2_q[i]) begin
              state_q[i] <= StLow;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == DebCnt) begin
              state_q[i]     <= StHigh;
              held_q[i]      <= 1'b1;
              pulse_q[i]     <= RiseEn;
              cnt_q[i]       <= '0;
              rep_q[i]       <= '0;
              rep_phase_q[i] <= 1'b0;
            end else begin
              cnt_q[i] <= cnt_inc[i];
            end
          end
          StHigh: begin
            if (!s2_q[i]) begin
              state_q[i] <= StHighPend;
              cnt_q[i]   <= CntOne;
            end else if (RepeatOn) begin
              if ((!rep_phase_q[i] && rep_inc[i] == HoldCnt) ||
                  (rep_phase_q[i] && rep_inc[i] == RepCnt)) begin
                // Suppressed if the previous cycle already pulsed.
                pulse_q[i]     <= ~pulse_q[i];
                rep_q[i]       <= '0;
                rep_phase_q[i] <= 1'b1;
              end else begin
                rep_q[i] <= rep_inc[i];
              end
            end
          end
          StHighPend: begin
            if (s2_q[i]) begin
              state_q[i] <= StHigh;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == DebCnt) begin
              state_q[i]     <= StLow;
              held_q[i]      <= 1'b0;
              pulse_q[i]     <= FallEn;
              cnt_q[i]       <= '0;
              rep_q[i]       <= '0;
              rep_phase_q[i] <= 1'b0;
            end else begin
              cnt_q[i] <= cnt_inc[i];
            end
          end
          default: state_q[i] <= StLow;
        endcase
      end
    end
  end

  assign pulse_o = pulse_q;
  assign held_o  = held_q;

endmodule

// File: tb/tb_debounced_edge_pulser.sv
// Bench for debounced_edge_pulser: directed scenarios plus randomized levels checked
// against a sample-window model of the debounce rule.
module tb_debounced_edge_pulser;

  localparam int D0 = 4;
  localparam int D2 = 3;
  localparam int HistLen = 32;

  logic       clk;
  logic       rst_n;
  logic [3:0] lvl0, lvl2, lvlr;
  logic [3:0] p0, h0, p2, h2, pr, hr;

  int checks = 0;
  int errors = 0;

  // Reference state: effective synchroniser input per edge, and the expected outputs.
  logic [3:0] hist0[$];
  logic [3:0] hist2[$];
  logic [3:0] exp_held0, exp_pulse0, exp_held2, exp_pulse2;

  debounced_edge_pulser #(
    .WIDTH(4), .DEBOUNCE_CYCLES(D0), .EDGE_MODE(0)
  ) u_m0 (
    .clk_i(clk), .rst_ni(rst_n), .level_i(lvl0), .pulse_o(p0), .held_o(h0)
  );

  debounced_edge_pulser #(
    .WIDTH(4), .DEBOUNCE_CYCLES(D2), .EDGE_MODE(2)
  ) u_m2 (
    .clk_i(clk), .rst_ni(rst_n), .level_i(lvl2), .pulse_o(p2), .held_o(h2)
  );

  debounced_edge_pulser #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .REPEAT_EN(1),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
  ) u_rep (
    .clk_i(clk), .rst_ni(rst_n), .level_i(lvlr), .pulse_o(pr), .held_o(hr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A level change is accepted once D+1 consecutive synchronised samples disagree
  // with the accepted level; the FSM sees the sample taken two edges earlier.
  function automatic logic [3:0] accepted(input logic [3:0] h[$], input logic [3:0] held,
                                          input int d);
    logic [3:0] acc;
    for (int ch = 0; ch < 4; ch++) begin
      acc[ch] = 1'b1;
      for (int k = 0; k <= d; k++)
        if (h[h.size() - 3 - k][ch] == held[ch]) acc[ch] = 1'b0;
    end
    return acc;
  endfunction

  task automatic clear_hist();
    hist0.delete();
    hist2.delete();
    for (int i = 0; i < HistLen; i++) begin
      hist0.push_back(4'h0);
      hist2.push_back(4'h0);
    end
  endtask

  task automatic step(input logic [3:0] l0, input logic [3:0] l2, input logic [3:0] lr,
                      input logic rn);
    logic [3:0] f0, f2;
    lvl0  = l0;
    lvl2  = l2;
    lvlr  = lr;
    rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      clear_hist();
      exp_held0  = '0;
      exp_pulse0 = '0;
      exp_held2  = '0;
      exp_pulse2 = '0;
    end else begin
      hist0.push_back(l0);
      hist2.push_back(l2);
      void'(hist0.pop_front());
      void'(hist2.pop_front());
      f0 = accepted(hist0, exp_held0, D0);
      f2 = accepted(hist2, exp_held2, D2);
      exp_pulse0 = f0 & ~exp_held0;
      exp_pulse2 = f2;
      exp_held0  = exp_held0 ^ f0;
      exp_held2  = exp_held2 ^ f2;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int t = 0; t < 3; t++) begin
      step(4'hF, 4'hF, 4'hF, 1'b0);
      checks++;
      if ({p0, h0, p2, h2, pr, hr} !== 24'h0) begin
        errors++;
        $display("FAIL reset_outputs t=%0d got p0=%h h0=%h p2=%h h2=%h pr=%h hr=%h want all 0",
                 t, p0, h0, p2, h2, pr, hr);
      end
    end
    // Released with levels already high: debounce runs normally.
    for (int t = 0; t < 10; t++) begin
      step(4'hF, 4'h0, 4'h0, 1'b1);
      checks++;
      if (p0 !== ((t == 6) ? 4'hF : 4'h0) || h0 !== ((t >= 6) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL reset_level_high t=%0d got pulse=%h held=%h want pulse=%h held=%h",
                 t, p0, h0, (t == 6) ? 4'hF : 4'h0, (t >= 6) ? 4'hF : 4'h0);
      end
    end
    for (int t = 0; t < 12; t++) step(4'h0, 4'h0, 4'h0, 1'b1);
  endtask

  task automatic test_single_press();
    for (int t = 0; t < 12; t++) begin
      step(4'h1, 4'h0, 4'h0, 1'b1);
      checks++;
      if (p0 !== ((t == 6) ? 4'h1 : 4'h0) || h0 !== ((t >= 6) ? 4'h1 : 4'h0)) begin
        errors++;
        $display("FAIL single_press t=%0d got pulse=%h held=%h want pulse=%h held=%h",
                 t, p0, h0, (t == 6) ? 4'h1 : 4'h0, (t >= 6) ? 4'h1 : 4'h0);
      end
    end
  endtask

  task automatic test_glitch();
    for (int t = 0; t < 12; t++) begin
      step((t < 3) ? 4'h3 : 4'h1, 4'h0, 4'h0, 1'b1);
      checks++;
      if (p0 !== 4'h0 || h0 !== 4'h1) begin
        errors++;
        $display("FAIL glitch t=%0d got pulse=%h held=%h want pulse=0 held=1", t, p0, h0);
      end
    end
  endtask

  task automatic test_mode_both();
    int n = 0;
    for (int t = 0; t < 25; t++) begin
      step(4'h1, (t < 10) ? 4'h4 : 4'h0, 4'h0, 1'b1);
      if (p2[2]) n++;
      checks++;
      if (p2 !== ((t == 5 || t == 15) ? 4'h4 : 4'h0) ||
          h2 !== ((t >= 5 && t < 15) ? 4'h4 : 4'h0)) begin
        errors++;
        $display("FAIL mode_both t=%0d got pulse=%h held=%h", t, p2, h2);
      end
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL mode_both_count got %0d pulses want 2", n);
    end
  endtask

  task automatic test_simultaneous();
    for (int t = 0; t < 12; t++) step(4'h0, 4'h0, 4'h0, 1'b1);
    for (int t = 0; t < 10; t++) begin
      step(4'hF, 4'h0, 4'h0, 1'b1);
      checks++;
      if (p0 !== ((t == 6) ? 4'hF : 4'h0) || h0 !== ((t >= 6) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL simultaneous t=%0d got pulse=%h held=%h", t, p0, h0);
      end
    end
  endtask

  task automatic test_reset_pending();
    for (int t = 0; t < 12; t++) step(4'h0, 4'h0, 4'h0, 1'b1);
    for (int t = 0; t < 4; t++) step(4'h8, 4'h0, 4'h0, 1'b1);
    for (int t = 0; t < 14; t++) begin
      step(4'h0, 4'h0, 4'h0, (t >= 2));
      checks++;
      if (p0 !== 4'h0 || h0 !== 4'h0) begin
        errors++;
        $display("FAIL reset_pending t=%0d got pulse=%h held=%h want 0 0", t, p0, h0);
      end
    end
  endtask

  task automatic test_repeat();
    logic want_p;
    logic want_h;
    for (int t = 0; t < 65; t++) begin
      step(4'h0, 4'h0, (t < 49) ? 4'h1 : 4'h0, 1'b1);
      want_p = (t == 6) || (t >= 26 && t <= 46 && (t - 26) % 5 == 0);
      want_h = (t >= 6 && t < 55);
      checks++;
      if (pr !== {3'b0, want_p} || hr !== {3'b0, want_h}) begin
        errors++;
        $display("FAIL repeat t=%0d got pulse=%h held=%h want pulse=%0d held=%0d",
                 t, pr, hr, want_p, want_h);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r0 = 4'h0;
    logic [3:0] r2 = 4'h0;
    logic [3:0] prev0 = 4'h0;
    for (int t = 0; t < 1500; t++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if ($urandom_range(7) == 0) r0[ch] = ~r0[ch];
        if ($urandom_range(6) == 0) r2[ch] = ~r2[ch];
      end
      step(r0, r2, 4'h0, 1'b1);
      checks++;
      if (p0 !== exp_pulse0 || h0 !== exp_held0 || (p0 & prev0) !== 4'h0) begin
        errors++;
        $display("FAIL random_m0 t=%0d got pulse=%h held=%h want pulse=%h held=%h",
                 t, p0, h0, exp_pulse0, exp_held0);
      end
      checks++;
      if (p2 !== exp_pulse2 || h2 !== exp_held2) begin
        errors++;
        $display("FAIL random_m2 t=%0d got pulse=%h held=%h want pulse=%h held=%h",
                 t, p2, h2, exp_pulse2, exp_held2);
      end
      prev0 = p0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    lvl0  = '0;
    lvl2  = '0;
    lvlr  = '0;
    clear_hist();
    exp_held0 = '0; exp_pulse0 = '0; exp_held2 = '0; exp_pulse2 = '0;
    test_reset();
    test_single_press();
    test_glitch();
    test_mode_both();
    test_simultaneous();
    test_reset_pending();
    test_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounced_edge_pulser.md
DEBOUNCED_EDGE_PULSER -- requirements
Module: debounced_edge_pulser

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input channels, range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronised cycles required to accept a level change, range 1..2^CNT_WIDTH-1.
REQ-003 Parameter EDGE_MODE, default 0: pulse on accepted rise (0), accepted fall (1), or both (2).
REQ-004 Parameter REPEAT_EN, default 0: 1 enables auto-repeat pulses while a channel is held high.
REQ-005 Parameter HOLD_CYCLES, default 1000: cycles from the press pulse to the first repeat pulse, range 1..2^CNT_WIDTH-1.
REQ-006 Parameter REPEAT_CYCLES, default 250: cycles between successive repeat pulses, range 1..2^CNT_WIDTH-1.
REQ-007 Parameter CNT_WIDTH, default 16: width of each per-channel counter.
REQ-008 Clock  input  1  system clock; all logic on rising edge.
REQ-009 Reset  input  1  synchronous, active-low reset; Reset=0 at a rising edge of Clock resets the block.
REQ-010 Level  input  WIDTH  raw asynchronous push-button levels, one bit per channel.
REQ-011 Pulse  output  WIDTH  registered one-cycle event pulse per channel.
REQ-012 Held  output  WIDTH  registered debounced level per channel.

Function
REQ-013 Each Level bit SHALL pass through a 2-flop synchroniser (s1, s2) before any other use; channels are fully independent.
REQ-014 Each channel SHALL run a 4-state FSM: LOW, LOW_PEND, HIGH, HIGH_PEND; Held=1 in HIGH and HIGH_PEND, else 0.
REQ-015 LOW: s2=1 -> LOW_PEND, counter cleared to 1; s2=0 -> stay.
REQ-016 LOW_PEND: s2=0 -> LOW, counter cleared; s2=1 and counter=DEBOUNCE_CYCLES -> HIGH; otherwise increment counter.
REQ-017 HIGH/HIGH_PEND SHALL mirror REQ-015/016 with the s2 polarity inverted; HIGH_PEND completion -> LOW.
REQ-018 With DEBOUNCE_CYCLES=1 the PEND state SHALL complete on its first cycle with s2 still changed (no count beyond 1).
REQ-019 Pulse SHALL be 1 for exactly the one cycle after the FSM enters HIGH (EDGE_MODE 0 or 2) or LOW from HIGH_PEND (EDGE_MODE 1 or 2); Held changes on the same edge Pulse rises.
REQ-020 Latency: with Level stable, Pulse and Held change DEBOUNCE_CYCLES+2 cycles after the edge that first samples the new Level into s1.
REQ-021 Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL produce no Pulse and no Held change.
REQ-022 Auto-repeat (REPEAT_EN=1 and EDGE_MODE!=1): in HIGH, a repeat counter cleared at entry SHALL pulse after HOLD_CYCLES cycles, then every REPEAT_CYCLES cycles while in HIGH.
REQ-023 Entering HIGH_PEND SHALL freeze the repeat counter; returning to HIGH resumes it; reaching LOW clears it; no repeat pulse SHALL fire in HIGH_PEND.
REQ-024 Counters SHALL saturate and never wrap; a parameter exceeding 2^CNT_WIDTH-1 is a configuration error flagged at elaboration.
REQ-025 Pulse SHALL never be high on two consecutive cycles for a channel.
REQ-026 Multiple channels changing on the same cycle SHALL each pulse independently in that cycle.

Reset
REQ-027 While Reset=0: s1, s2, all counters cleared; every FSM in LOW; Pulse=0; Held=0.
REQ-028 Reset asserted mid-debounce or mid-hold SHALL discard the pending event; no Pulse on the cycle after release.
REQ-029 After release with Level already high, the channel SHALL debounce normally and pulse per REQ-020 (EDGE_MODE 0/2).

Verification
REQ-030 WIDTH=4, D=4, mode 0: Level[0] 0->1 held -> Pulse[0]=1 for one cycle 6 cycles after first sample, Held[0]=1 from then; others 0.
REQ-031 D=4: Level[1] high for 3 cycles then low -> Pulse=0, Held=0 throughout.
REQ-032 Mode 2: press then release channel 2 (each stable 10 cycles) -> exactly two Pulse[2] events, one per transition.
REQ-033 REPEAT_EN=1, HOLD=20, REPEAT=5: hold channel 0 for 40 cycles past press pulse -> pulses at +0, +20, +25, +30, +35, +40.
REQ-034 Level[3:0]=4'hF simultaneously -> Pulse=4'hF in one cycle; Reset=0 during LOW_PEND -> no Pulse, Held=0.
